// File: rtl/core_mem_pkg.sv
// rtl/core_mem_pkg.sv - shared access-size and bridge state encodings
package core_mem_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RD_WAIT    = 2'd1,
        WR_DONE    = 2'd2,
        FAULT_DONE = 2'd3
    } bridge_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering, load extension and misalignment detect
module mem_lane_align
    import core_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [31:0] store_data,
    input  logic [31:0] read_raw,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata,
    output logic [31:0] read_ext,
    output logic        misalign
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        byte_en  = 4'b1111;
        wdata    = store_data;
        read_ext = read_raw;
        misalign = 1'b0;
        rd_byte  = read_raw[{addr_lo, 3'b000} +: 8];
        rd_half  = addr_lo[1] ? read_raw[31:16] : read_raw[15:0];

        case (size)
            MEM_SIZE_B: begin
                byte_en  = 4'b0001 << addr_lo;
                wdata    = {4{store_data[7:0]}};
                read_ext = {{24{rd_byte[7] & ~zero_ext}}, rd_byte};
            end
            MEM_SIZE_H: begin
                byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{store_data[15:0]}};
                read_ext = {{16{rd_half[15] & ~zero_ext}}, rd_half};
                misalign = addr_lo[0];
            end
            // size 3 is an alias for a full word
            default: begin
                misalign = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/core_mem_bridge.sv
// rtl/core_mem_bridge.sv - fetch/load/store arbiter onto one synchronous-read SRAM port
module core_mem_bridge
    import core_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_valid,
    input  logic [31:0]           fetch_addr,
    output logic [31:0]           fetch_data,
    output logic                  fetch_ready,
    output logic                  fetch_fault,
    input  logic                  mem_read_valid,
    input  logic                  mem_write_valid,
    input  logic [31:0]           mem_addr,
    input  logic [1:0]            mem_size,
    input  logic                  mem_unsigned,
    input  logic [31:0]           mem_write_data,
    output logic [31:0]           mem_read_data,
    output logic                  mem_ready,
    output logic                  mem_fault,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    localparam int AW = ADDR_WIDTH + 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    size;
        logic          zero_ext;
        logic [31:0]   wdata;
        logic          wr;
    } op_t;

    bridge_state_t state, next_state;
    logic          settle;

    logic          f_pend;
    logic [AW-1:0] f_slot_addr;
    logic          d_pend;
    op_t           d_slot;
    op_t           act_op;
    logic          act_fetch;

    logic          data_req;
    op_t           data_in, data_eff, fetch_op, sel_op, cur_op;
    logic          pick_data, pick_fetch, pick, issue;

    logic [3:0]    lane_we;
    logic [31:0]   lane_wdata;
    logic [31:0]   lane_rdata;
    logic          misalign;

    logic          unused_bits;
    assign unused_bits = ^{mem_addr[31:AW], fetch_addr[31:AW], act_op.wr};

    assign data_req = mem_read_valid | mem_write_valid;

    // A request arriving in IDLE bypasses its slot and is issued on the same edge.
    always_comb begin
        data_in    = '{addr: mem_addr[AW-1:0], size: mem_size, zero_ext: mem_unsigned,
                       wdata: mem_write_data, wr: mem_write_valid};
        data_eff   = d_pend ? d_slot : data_in;
        fetch_op   = '{addr: (f_pend ? f_slot_addr : fetch_addr[AW-1:0]), size: MEM_SIZE_W,
                       zero_ext: 1'b0, wdata: 32'd0, wr: 1'b0};
        pick_data  = (state == IDLE) && (d_pend || data_req);
        pick_fetch = (state == IDLE) && !pick_data && (f_pend || fetch_valid);
        pick       = pick_data | pick_fetch;
        sel_op     = pick_data ? data_eff : fetch_op;
        cur_op     = (state == IDLE) ? sel_op : act_op;
    end

    assign issue = pick && !misalign;

    mem_lane_align u_lane (
        .addr_lo    (cur_op.addr[1:0]),
        .size       (cur_op.size),
        .zero_ext   (cur_op.zero_ext),
        .store_data (cur_op.wdata),
        .read_raw   (ram_rdata),
        .byte_en    (lane_we),
        .wdata      (lane_wdata),
        .read_ext   (lane_rdata),
        .misalign   (misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pick) begin
                    if (misalign) begin
                        next_state = FAULT_DONE;
                    end else if (sel_op.wr) begin
                        next_state = WR_DONE;
                    end else begin
                        next_state = RD_WAIT;
                    end
                end
            end
            RD_WAIT, WR_DONE: begin
                if (settle) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // settle marks the second cycle of an access: the RAM has taken ram_en and rdata is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle        <= 1'b0;
            f_pend        <= 1'b0;
            f_slot_addr   <= '0;
            d_pend        <= 1'b0;
            d_slot        <= '0;
            act_op        <= '0;
            act_fetch     <= 1'b0;
            fetch_data    <= 32'd0;
            fetch_ready   <= 1'b0;
            fetch_fault   <= 1'b0;
            mem_read_data <= 32'd0;
            mem_ready     <= 1'b0;
            mem_fault     <= 1'b0;
            ram_en        <= 1'b0;
            ram_we        <= 4'd0;
            ram_addr      <= '0;
            ram_wdata     <= 32'd0;
        end else begin
            settle      <= ((state == RD_WAIT) || (state == WR_DONE)) && !settle;
            fetch_ready <= 1'b0;
            fetch_fault <= 1'b0;
            mem_ready   <= 1'b0;
            mem_fault   <= 1'b0;
            ram_en      <= 1'b0;
            ram_we      <= 4'd0;

            if (pick_fetch) begin
                f_pend <= 1'b0;
            end else if (fetch_valid && !f_pend) begin
                f_pend      <= 1'b1;
                f_slot_addr <= fetch_addr[AW-1:0];
            end

            if (pick_data) begin
                d_pend <= 1'b0;
            end else if (data_req && !d_pend) begin
                d_pend <= 1'b1;
                d_slot <= data_in;
            end

            if (pick) begin
                act_op    <= sel_op;
                act_fetch <= pick_fetch;
            end

            if (issue) begin
                ram_en    <= 1'b1;
                ram_we    <= sel_op.wr ? lane_we : 4'd0;
                ram_addr  <= sel_op.addr[AW-1:2];
                ram_wdata <= lane_wdata;
            end

            case (state)
                RD_WAIT: begin
                    if (settle) begin
                        if (act_fetch) begin
                            fetch_data  <= ram_rdata;
                            fetch_ready <= 1'b1;
                        end else begin
                            mem_read_data <= lane_rdata;
                            mem_ready     <= 1'b1;
                        end
                    end
                end
                WR_DONE: begin
                    if (settle) begin
                        mem_ready <= 1'b1;
                    end
                end
                FAULT_DONE: begin
                    if (act_fetch) begin
                        fetch_data  <= 32'd0;
                        fetch_ready <= 1'b1;
                        fetch_fault <= 1'b1;
                    end else begin
                        mem_read_data <= 32'd0;
                        mem_ready     <= 1'b1;
                        mem_fault     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(mem_read_valid && mem_write_valid));
    assert property (@(posedge clk) disable iff (!rst_n) !(fetch_valid && f_pend));
    assert property (@(posedge clk) disable iff (!rst_n) !(data_req && d_pend));

endmodule

// File: doc/core_mem_bridge.md
Name: core_mem_bridge

Overview:
Single-port memory bridge directly downstream of the core's fetch and data-memory interfaces. It arbitrates instruction fetches and load/store requests onto one synchronous-read SRAM port, does byte-lane steering and sign/zero extension, and returns held results with one-cycle ready pulses. Misaligned accesses are rejected with a fault instead of touching the RAM.

Parameters:
ADDR_WIDTH, 10, number of RAM word-address bits (RAM depth = 2**ADDR_WIDTH words of 32 bits)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
fetch_valid  in  1  single-cycle fetch request pulse
fetch_addr  in  32  byte address of instruction
fetch_data  out  32  fetched instruction, held until next fetch completes
fetch_ready  out  1  one-cycle pulse: fetch_data/fetch_fault valid
fetch_fault  out  1  fetch was misaligned (valid with fetch_ready)
mem_read_valid  in  1  single-cycle load request pulse
mem_write_valid  in  1  single-cycle store request pulse
mem_addr  in  32  byte address of load/store
mem_size  in  2  0 = byte, 1 = half, 2 = word (3 treated as word)
mem_unsigned  in  1  1 = zero-extend load result, 0 = sign-extend
mem_write_data  in  32  store data, right-aligned
mem_read_data  out  32  extended load result, held until next data op completes
mem_ready  out  1  one-cycle pulse: data op complete
mem_fault  out  1  data op misaligned (valid with mem_ready)
ram_en  out  1  RAM access enable
ram_we  out  4  RAM byte write enables, bit n = bits [8n+7:8n]
ram_addr  out  ADDR_WIDTH  RAM word address
ram_wdata  out  32  RAM write data, lane-steered
ram_rdata  in  32  RAM read data, valid the cycle after ram_en sampled

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, both pending flags clear; every output 0 (fetch_data, mem_read_data, ready/fault pulses, ram_*). Any in-flight operation is dropped; no ready pulse is produced for it after reset.
- Requests are sampled on the rising edge into a pending fetch slot and a pending data slot (address, size, unsigned, write data, rd/wr). A new request of a kind that is already pending is a protocol violation: ignored, assertion fires.
- mem_read_valid and mem_write_valid high together is a violation: the store wins, assertion fires.
- All ram_* outputs are registered.
- Arbitration in IDLE: data slot first, otherwise fetch slot. A fetch arriving together with a data request waits until the data op completes.
- FSM:
  - IDLE.
  - RD_WAIT: ram_en was issued for a read. On the next edge, capture ram_rdata into fetch_data or the extended mem_read_data, pulse the matching ready, return to IDLE.
  - WR_DONE: ram_en with ram_we was issued. Next edge pulses mem_ready, returns to IDLE.
- Latency from request edge to ready edge:
  - fetch/load: 2 cycles (edge T sample + issue, edge T+1 RAM read, edge T+2 capture + ready).
  - store: 2 cycles.
  - fault: 1 cycle.
- Alignment:
  - fetch: fetch_addr[1:0] != 0 is a fault.
  - half: addr[0] = 1 is a fault.
  - word: addr[1:0] != 0 is a fault.
  - A faulting op issues no RAM access. It pulses ready + fault one edge after selection and forces the held data output to 0.
- ram_addr = addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap/alias.
- Stores:
  - byte: ram_we = 1 << addr[1:0], ram_wdata = byte replicated x4.
  - half: ram_we = 0011 or 1100 by addr[1], ram_wdata = half replicated x2.
  - word: ram_we = 1111.
- Loads: select lane by addr[1:0] (byte) or addr[1] (half), then sign- or zero-extend to 32 bits per mem_unsigned; word passes through.
- ram_en and ram_we are high exactly one cycle per access, and are 0 in every other cycle.
- fetch_data and mem_read_data change only at their own completion edge. The core may read them combinationally until the next request.
- After one ready, a back-to-back pending op is selected on the same edge IDLE is re-entered, giving a 1-cycle gap.

Decomposition:
- Shared package core_mem_pkg: MEM_SIZE_B/H/W encodings; the bridge state encodings IDLE/RD_WAIT/WR_DONE/FAULT_DONE.
- The core reuses the size encodings when driving mem_size.
- One combinational sub-module, mem_lane_align: takes addr[1:0], size, unsigned, store data and raw read data. It produces ram_we, steered wdata, the extended read result and misalign.

Test Plan:
- Preload word 0 = 32'h00500093, fetch_valid with addr 0 -> fetch_ready 2 cycles later, fetch_data = 32'h00500093 held until next fetch, fetch_fault = 0.
- Store byte 8'hA5 at addr 6 -> ram_we = 4'b0100, ram_addr = 1, ram_wdata = 32'hA5A5A5A5. Then lb addr 6 -> mem_read_data = 32'hFFFFFFA5; lbu -> 32'h000000A5.
- sh 16'h8001 at addr 2, then lh addr 2 -> 32'hFFFF8001; lhu -> 32'h00008001; lw addr 0 -> upper half 16'h8001.
- lw addr 5 -> mem_ready + mem_fault 1 cycle later, ram_en never asserted, mem_read_data = 0; fetch addr 2 -> fetch_fault = 1.
- fetch_valid and mem_read_valid on the same edge -> load serviced first (mem_ready at T+2), fetch_ready at T+5, both results correct.
- rst_n dropped during RD_WAIT -> all outputs 0 immediately, no ready pulse after release. Then address 2**(ADDR_WIDTH+2) reads the same word as address 0.
